// File: rtl/zin_ctrl.sv
// zin_ctrl: load-side burst controller. It accepts a burst of source beats over
// a valid/ready handshake, and for each beat it drives a PSU load strobe and a
// source read address. It steps the destination TAPU index after every group of
// beats and pulses done when the final beat is taken.
module zin_ctrl #(
  parameter int DEPTH_W      = 8,
  parameter int TAPU_DEPTH_W = 5,
  parameter int TAPU_IDX_W   = 3,
  parameter int ADDR_W       = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    zin_start,
  output logic                    zin_done,
  output logic                    zin_busy,
  input  logic [DEPTH_W-1:0]      load_depth,
  input  logic [TAPU_DEPTH_W-1:0] load_tapu_depth,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic                    psu_load_en,
  output logic [TAPU_IDX_W-1:0]   tapu_load_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [DEPTH_W-1:0]      r_depth;
  logic [TAPU_DEPTH_W-1:0] r_tapu_depth;
  logic [ADDR_W-1:0]       r_base;
  logic [DEPTH_W-1:0]      r_beat_cnt;
  logic [TAPU_DEPTH_W-1:0] r_tapu_cnt;
  logic [TAPU_IDX_W-1:0]   r_tapu_idx;
  logic                    w_beat;
  logic                    w_last;
  logic                    w_accept_start;

  // Start is only honoured from IDLE; a start seen during LOAD is dropped.
  assign w_accept_start = (r_state == IDLE) && zin_start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the values present before the edge, regardless of block order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode and handshake outputs; ready depends on state only.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    zin_busy     = 1'b0;
    src_ready    = 1'b0;
    psu_load_en  = 1'b0;
    zin_done     = 1'b0;
    w_beat       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (zin_start) w_next_state = LOAD;
      end
      LOAD: begin
        zin_busy    = 1'b1;
        src_ready   = 1'b1;
        w_beat      = src_valid;
        psu_load_en = src_valid;
        w_last      = src_valid && (r_beat_cnt == r_depth);
        zin_done    = w_last;
        if (w_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Burst configuration capture and beat/TAPU counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth      <= '0;
      r_tapu_depth <= '0;
      r_base       <= '0;
      r_beat_cnt   <= '0;
      r_tapu_cnt   <= '0;
      r_tapu_idx   <= '0;
    end else if (w_accept_start) begin
      r_depth      <= load_depth;
      r_tapu_depth <= load_tapu_depth;
      r_base       <= base_addr;
      r_beat_cnt   <= '0;
      r_tapu_cnt   <= '0;
      r_tapu_idx   <= '0;
    end else if (w_beat) begin
      // The beat counter returns to zero after the final beat; the TAPU index
      // is left alone so it still shows the last destination while idle.
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + DEPTH_W'(1);
      if (r_tapu_cnt == r_tapu_depth) begin
        r_tapu_cnt <= '0;
        r_tapu_idx <= r_tapu_idx + TAPU_IDX_W'(1);
      end else begin
        r_tapu_cnt <= r_tapu_cnt + TAPU_DEPTH_W'(1);
      end
    end
  end

  // Source address wraps naturally at the ADDR_W boundary.
  assign rd_addr       = r_base + ADDR_W'(r_beat_cnt);
  assign tapu_load_idx = r_tapu_idx;

endmodule

// File: tb/tb_zin_ctrl.sv
// Testbench for zin_ctrl: directed bursts from the test plan plus randomized
// bursts, compared each cycle against a beat-count reference model.
module tb_zin_ctrl;

  logic       clk;
  logic       rst_n;
  logic       zin_start;
  logic       zin_done;
  logic       zin_busy;
  logic [7:0] load_depth;
  logic [4:0] load_tapu_depth;
  logic [9:0] base_addr;
  logic       src_valid;
  logic       src_ready;
  logic [9:0] rd_addr;
  logic       psu_load_en;
  logic [2:0] tapu_load_idx;

  int errors = 0;
  int checks = 0;

  // Reference model: burst configuration and beats accepted since the start.
  bit m_busy;
  int m_n;
  int m_depth;
  int m_td;
  int m_base;

  zin_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .zin_start       (zin_start),
    .zin_done        (zin_done),
    .zin_busy        (zin_busy),
    .load_depth      (load_depth),
    .load_tapu_depth (load_tapu_depth),
    .base_addr       (base_addr),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .rd_addr         (rd_addr),
    .psu_load_en     (psu_load_en),
    .tapu_load_idx   (tapu_load_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_n     = 0;
    m_depth = 0;
    m_td    = 0;
    m_base  = 0;
  endtask

  // One clock: drive inputs, compare outputs at the falling edge, advance the
  // model at the rising edge. Entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit start, input bit valid);
    bit beat;
    zin_start = start;
    src_valid = valid;
    @(negedge clk);
    beat = m_busy && valid;
    check("busy", 32'(zin_busy), 32'(m_busy));
    check("ready", 32'(src_ready), 32'(m_busy));
    check("load_en", 32'(psu_load_en), 32'(beat));
    check("done", 32'(zin_done), 32'(beat && (m_n == m_depth)));
    check("tapu_idx", 32'(tapu_load_idx), 32'((m_n / (m_td + 1)) % 8));
    if (m_busy) check("rd_addr", 32'(rd_addr), 32'((m_base + m_n) % 1024));
    @(posedge clk);
    if (beat) begin
      m_n++;
      if (m_n > m_depth) m_busy = 1'b0;
    end else if (!m_busy && start) begin
      m_busy  = 1'b1;
      m_n     = 0;
      m_depth = int'(load_depth);
      m_td    = int'(load_tapu_depth);
      m_base  = int'(base_addr);
    end
    #1;
  endtask

  // mode 0: valid always high; 1: valid pattern 1,0,0; 2: random valid;
  // 3: random valid with zin_start held high throughout the burst.
  task automatic burst(input int depth, input int td, input int base, input int mode);
    int  guard;
    bit  v;
    load_depth      = 8'(depth);
    load_tapu_depth = 5'(td);
    base_addr       = 10'(base);
    cycle(1'b1, 1'($urandom % 2));
    guard = 0;
    while (m_busy && guard < 3000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 3 == 0);
        default: v = 1'($urandom % 2);
      endcase
      if ($urandom % 4 == 0) begin
        load_depth      = 8'($urandom);
        load_tapu_depth = 5'($urandom);
        base_addr       = 10'($urandom);
      end
      cycle(mode == 3, v);
      guard++;
    end
    checks++;
    assert (!m_busy) else begin
      errors++;
      $error("FAIL burst_timeout observed=busy expected=idle at %0t", $time);
    end
    cycle(1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; zin_start = 1'b0; src_valid = 1'b0;
    load_depth = '0; load_tapu_depth = '0; base_addr = '0;
    model_reset();
    #12;
    check("rst_done", 32'(zin_done), 32'd0);
    check("rst_busy", 32'(zin_busy), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_load_en", 32'(psu_load_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_tapu_idx", 32'(tapu_load_idx), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    cycle(1'b0, 1'b1);                 // idle with valid: nothing accepted
    burst(7, 1, 'h010, 0);             // basic burst
    burst(7, 1, 'h010, 1);             // stalls
    burst(255, 0, 'h3FE, 0);           // address and index wrap, 256 beats
    burst(0, 3, 'h155, 0);             // single beat
    burst(0, 0, 'h3FF, 2);
    burst(9, 2, 'h0A0, 3);             // start held high incl. final beat
    burst(5, 4, 'h200, 0);             // later start clears tapu index

    // Reset abort at beat 3 of 8.
    load_depth = 8'd7; load_tapu_depth = 5'd1; base_addr = 10'h010;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    zin_start = 1'b0; src_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("abort_done", 32'(zin_done), 32'd0);
    check("abort_busy", 32'(zin_busy), 32'd0);
    check("abort_ready", 32'(src_ready), 32'd0);
    check("abort_load_en", 32'(psu_load_en), 32'd0);
    check("abort_rd_addr", 32'(rd_addr), 32'd0);
    check("abort_tapu_idx", 32'(tapu_load_idx), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    burst(7, 1, 'h010, 0);

    for (int i = 0; i < 12; i++) begin
      burst(int'($urandom_range(0, 40)), int'($urandom_range(0, 6)),
            int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
